// File: rtl/mdl_relpgrewind_if.sv
// Seek/load/position bus of the reverse relative-page engine.
// master = host side (drives requests), slave = the engine.
interface mdl_relpgrewind_if;
    logic        i_POS_LD;
    logic [11:0] i_POS_D;
    logic        i_SEEK_REQ;
    logic [11:0] i_SEEK_TGT;
    logic        i_SEEK_ABORT;
    logic        o_SEEK_BUSY;
    logic        o_SEEK_DONE;
    logic        o_SEEK_ERR;
    logic [11:0] o_STEPS;
    logic        o_POS_LSB;
    logic [11:0] o_POS;

    modport master (
        output i_POS_LD, i_POS_D, i_SEEK_REQ, i_SEEK_TGT, i_SEEK_ABORT,
        input  o_SEEK_BUSY, o_SEEK_DONE, o_SEEK_ERR, o_STEPS, o_POS_LSB, o_POS
    );
    modport slave (
        input  i_POS_LD, i_POS_D, i_SEEK_REQ, i_SEEK_TGT, i_SEEK_ABORT,
        output o_SEEK_BUSY, o_SEEK_DONE, o_SEEK_ERR, o_STEPS, o_POS_LSB, o_POS
    );
endinterface

// File: rtl/mdl_relpgrewind.sv
// Bit-serial reverse page-position engine (mod 2053, step -522) with a rewind-to-target seek FSM.
// Optional macro RELPG_SEEK_TIMEOUT_EN adds the ERR state after 2053 unmatched steps.
module mdl_relpgrewind (
    input  logic             i_MCLK,
    input  logic             i_RST_n,
    input  logic             i_CLK2M_PCEN_n,
    input  logic [19:0]      i_ROT20_n,
    mdl_relpgrewind_if.slave bus
);
    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_SEEK = 2'd1;
    localparam logic [1:0]  ST_DONE = 2'd2;
    localparam logic [1:0]  ST_ERR  = 2'd3;
    localparam logic [11:0] C_SUB   = 12'hDF6;   // -522 in 12 bits
    localparam logic [11:0] C_WRAP  = 12'h5FB;   // +1531 = -522 + 2053
    localparam logic [11:0] C_CMP   = 12'h20A;   // 522
    localparam logic [11:0] C_MOD   = 12'd2053;
    localparam logic [11:0] C_SAT   = 12'hFFF;

    logic [11:0] r_pos, r_tgt, r_steps, r_pos_snap, r_ld_d;
    logic        r_carry, r_g, r_ge, r_step_en, r_ld_pend;
    logic [1:0]  r_state;

    logic [19:0] w_slot;
    logic [4:0]  w_k;
    logic        w_en, w_any, w_shift, w_s0, w_s12, w_s19;
    logic [11:0] w_const, w_ld_val;
    logic        w_cbit, w_gbit, w_sum, w_cout, w_g_in, w_g;
    logic        w_match, w_timeout, w_abort, w_ld, w_start;

    genvar gi;
    generate
        for (gi = 0; gi < 20; gi++) begin : g_slot
            assign w_slot[gi] = ~i_ROT20_n[gi];
        end
    endgenerate

    always_comb begin
        w_k = 5'd0;
        for (int i = 0; i < 20; i++)
            if (w_slot[i]) w_k = w_k | 5'(i);
    end

    assign w_en    = ~i_CLK2M_PCEN_n;
    assign w_any   = |w_slot;
    assign w_shift = w_any & (w_k < 5'd12);
    assign w_s0    = w_any & (w_k == 5'd0);
    assign w_s12   = w_any & (w_k == 5'd12);
    assign w_s19   = w_any & (w_k == 5'd19);

    // Addend bit for the current slot; zero outside slots 0-11 or when not stepping.
    assign w_const = r_step_en ? (r_ge ? C_SUB : C_WRAP) : 12'd0;
    assign w_cbit  = |(w_const & w_slot[11:0]);
    assign w_gbit  = |(C_CMP & w_slot[11:0]);
    assign w_sum   = r_pos[0] ^ w_cbit ^ r_carry;
    assign w_cout  = (r_pos[0] & w_cbit) | (r_pos[0] & r_carry) | (w_cbit & r_carry);

    // LSB-first magnitude compare of the new value against 522; higher bits override.
    assign w_g_in  = w_s0 ? 1'b1 : r_g;
    assign w_g     = (w_sum & ~w_gbit) | (~(w_sum ^ w_gbit) & w_g_in);

    assign w_ld_val = (r_ld_d >= C_MOD) ? (r_ld_d - C_MOD) : r_ld_d;
    assign w_match  = (r_pos == r_tgt);
    assign w_abort  = bus.i_SEEK_ABORT;
    assign w_ld     = bus.i_POS_LD;
    assign w_start  = bus.i_SEEK_REQ & ~w_abort & ~w_ld & ~r_ld_pend;

`ifdef RELPG_SEEK_TIMEOUT_EN
    assign w_timeout      = (r_steps == C_MOD);
    assign bus.o_SEEK_ERR = (r_state == ST_ERR);
`else
    assign w_timeout      = 1'b0;
    assign bus.o_SEEK_ERR = 1'b0;
`endif

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_pos      <= 12'd0;
            r_carry    <= 1'b0;
            r_g        <= 1'b0;
            r_ge       <= 1'b0;
            r_pos_snap <= 12'd0;
        end else if (w_en) begin
            if (w_shift) begin
                r_pos   <= {w_sum, r_pos[11:1]};
                r_carry <= w_cout;
                r_g     <= w_g;
            end
            if (w_s12)
                r_pos_snap <= r_pos;
            if (w_s19) begin
                r_carry <= 1'b0;
                r_ge    <= r_g;
                if (r_ld_pend) begin
                    r_pos <= w_ld_val;
                    r_ge  <= (w_ld_val >= 12'd522);
                end
            end
        end
    end

    // A load waits for the frame boundary so the serial register is never split mid-frame.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_ld_pend <= 1'b0;
            r_ld_d    <= 12'd0;
        end else if (w_en) begin
            if (w_s19)
                r_ld_pend <= 1'b0;
            if (w_ld) begin
                r_ld_pend <= 1'b1;
                r_ld_d    <= bus.i_POS_D;
            end
        end
    end

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_state   <= ST_IDLE;
            r_tgt     <= 12'd0;
            r_steps   <= 12'd0;
            r_step_en <= 1'b0;
        end else if (w_en) begin
            if (w_s19)
                r_step_en <= (r_state == ST_SEEK) & ~w_abort & ~w_ld & ~w_match & ~w_timeout;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_SEEK;
                        r_tgt   <= bus.i_SEEK_TGT;
                        r_steps <= 12'd0;
                    end
                end
                ST_SEEK: begin
                    if (w_abort | w_ld)
                        r_state <= ST_IDLE;
                    else if (w_s19) begin
                        if (w_match)
                            r_state <= ST_DONE;
                        else if (w_timeout)
                            r_state <= ST_ERR;
                        else if (r_steps != C_SAT)
                            r_steps <= r_steps + 12'd1;
                    end
                end
                ST_DONE, ST_ERR: begin
                    if (w_abort | bus.i_SEEK_REQ)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_SEEK_BUSY = (r_state == ST_SEEK);
    assign bus.o_SEEK_DONE = (r_state == ST_DONE);
    assign bus.o_STEPS     = r_steps;
    assign bus.o_POS_LSB   = w_sum;
    assign bus.o_POS       = r_pos_snap;
endmodule
